// File: rtl/div_defs_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and fixed results.
package div_defs;

  localparam int unsigned DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Quotient reported on divide-by-zero; truncated to the operand width at use.
  localparam logic [31:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational ripple subtractor (a + ~b + 1) for the divider trial step, plus its full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module div_trial_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // No carry out of a + ~b + 1 means a < b.
  assign borrow = ~carry[N];
endmodule

// File: rtl/seq_divider_4bit.sv
// Sequential unsigned restoring divider: one shift/trial-subtract per clock, start/busy/done handshake.
module seq_divider_4bit
  import div_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state, state_next;
  logic [WIDTH:0]   r, r_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] dvs, dvs_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             busy_next, done_next, dbz_next;
  logic [WIDTH-1:0] quot_next, rem_next;

  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_borrow;
  logic             unused_r_msb;

  assign trial_a      = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial_b      = {1'b0, dvs};
  // The partial remainder always stays below the divisor, so its top bit is never consumed.
  assign unused_r_msb = r[WIDTH];

  div_trial_sub #(.N(WIDTH + 1)) u_trial (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      r           <= r_next;
      q           <= q_next;
      dvs         <= dvs_next;
      cnt         <= cnt_next;
      busy        <= busy_next;
      done        <= done_next;
      quotient    <= quot_next;
      remainder   <= rem_next;
      div_by_zero <= dbz_next;
    end
  end

  // Next-state, datapath and registered-output logic; results load only on entry to DONE.
  always_comb begin
    state_next = state;
    r_next     = r;
    q_next     = q;
    dvs_next   = dvs;
    cnt_next   = cnt;
    busy_next  = busy;
    done_next  = 1'b0;
    quot_next  = quotient;
    rem_next   = remainder;
    dbz_next   = div_by_zero;

    case (state)
      S_IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          dvs_next  = divisor;
          busy_next = 1'b1;
          if (divisor == '0) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            quot_next  = WIDTH'(DIV_ZERO_QUOT);
            rem_next   = dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = S_CALC;
            r_next     = '0;
            q_next     = dividend;
            cnt_next   = '0;
          end
        end
      end
      S_CALC: begin
        if (!trial_borrow) begin
          r_next = trial_diff;
          q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_next = {r[WIDTH-1:0], q[WIDTH-1]};
          q_next = {q[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          quot_next  = q_next;
          rem_next   = r_next[WIDTH-1:0];
          dbz_next   = 1'b0;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
